// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional perf counters: define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       mem_wb_flush,
  output logic       mem_timeout,
  output logic [1:0] ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t          state;
  logic [TO_W-1:0] wait_cnt;
  logic            wait_miss;
  logic            lu;
  logic            freeze;
  logic            rd_hit;
  logic            lu_hit;

  assign wait_miss = mem_req & ~dmem_ready;

  assign lu = ex_mem_read & (ex_rd_addr != 5'd0) &
              ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
               (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));

  assign freeze = (state == HALT) | wait_miss;
  assign rd_hit = ex_redirect & ~freeze;
  assign lu_hit = lu & ~ex_redirect & ~freeze;

  // Exclusive terms encode the freeze > redirect > load-use priority.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        freeze: begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
        end
        rd_hit: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        lu_hit: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (wait_miss) begin
            state    <= MEM_WAIT;
            wait_cnt <= TO_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready || !mem_req) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TO_W'(MEM_TIMEOUT)) begin
            state       <= HALT;
            mem_timeout <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

  assign ctrl_state = state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (pc_stall)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (id_ex_flush)
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: random + directed stimulus
// against a cycle-level reference model (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b1;
  logic       rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_mem_read, ex_redirect;
  logic       mem_req, dmem_ready;
  logic       pc_stall, if_id_stall, if_id_flush;
  logic       id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, mem_wb_flush;
  logic       mem_timeout;
  logic [1:0] ctrl_state;
  logic [31:0] perf_s, perf_f;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(TO),
    .TO_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect),
    .mem_req(mem_req),
    .dmem_ready(dmem_ready),
    .pc_stall(pc_stall),
    .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall),
    .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout),
    .ctrl_state(ctrl_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cycles(perf_s),
    .perf_flush_count(perf_f)
`endif
  );

`ifndef PIPE_HAZARD_CTRL_PERF_EN
  assign perf_s = '0;
  assign perf_f = '0;
`endif

  always #5 clk = ~clk;

  // {perf_stall, perf_flush, 7 stall/flush bits, timeout, state}
  logic [73:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model state
  int  m_waits;
  bit  m_halt;
  int  m_ps, m_pf;
  bit  e_ps, e_ff;

  task automatic clr();
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_redirect = 0;
    mem_req = 0; dmem_ready = 0;
  endtask

  task automatic cycle();
    bit lu, frz, rd, luh;
    bit [6:0] o;
    bit [1:0] st;
    if (!rst_n) begin
      m_waits = 0; m_halt = 0; m_ps = 0; m_pf = 0;
    end
    lu = ex_mem_read && ex_rd_addr != 0 &&
         ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
          (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    frz = m_halt || (mem_req && !dmem_ready);
    rd  = ex_redirect && !frz;
    luh = lu && !ex_redirect && !frz;
    // order: pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, memwb_f
    o = 7'b0;
    if (rst_n) begin
      if (frz)      o = 7'b1101011;
      else if (rd)  o = 7'b0010100;
      else if (luh) o = 7'b1100100;
    end
    st = m_halt ? 2'd2 : (m_waits > 0 ? 2'd1 : 2'd0);
    exp_q.push_back({m_ps[31:0], m_pf[31:0], o, m_halt, st});
    e_ps = o[6];
    e_ff = o[2];
    @(posedge clk);
    if (!rst_n) begin
      m_waits = 0; m_halt = 0; m_ps = 0; m_pf = 0;
    end else begin
      m_ps += e_ps;
      m_pf += e_ff;
      if (!m_halt) begin
        if (mem_req && !dmem_ready) begin
          if (m_waits == TO) m_halt = 1;
          else m_waits++;
        end else begin
          m_waits = 0;
        end
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // monitor: compares at the falling edge
  always @(negedge clk) begin
    logic [73:0] e;
    logic [8:0]  g;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_flush, ex_mem_stall, mem_wb_flush, mem_timeout,
           ctrl_state[1]};
      n_cmp++;
      if ({g, ctrl_state[0]} !== e[9:0]) begin
        n_bad++;
        $display("FAIL outs cyc=%0d got=%b required=%b",
                 cyc, {g, ctrl_state[0]}, e[9:0]);
      end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      n_cmp++;
      if (perf_s !== e[73:42] || perf_f !== e[41:10]) begin
        n_bad++;
        $display("FAIL perf cyc=%0d got=%0d/%0d required=%0d/%0d",
                 cyc, perf_s, perf_f, e[73:42], e[41:10]);
      end
`endif
    end
  end

  initial begin
    clr();
    rst_n = 0;
    run(2);
    rst_n = 1;
    run(1);
    // load-use, then same with x0
    ex_mem_read = 1; ex_rd_addr = 5;
    id_uses_rs1 = 1; id_rs1_addr = 5;
    run(1);
    ex_rd_addr = 0; id_rs1_addr = 0;
    run(1);
    // rs2 load-use
    clr(); ex_mem_read = 1; ex_rd_addr = 9;
    id_uses_rs2 = 1; id_rs2_addr = 9;
    run(1);
    // redirect + load-use
    ex_rd_addr = 5; id_uses_rs1 = 1; id_rs1_addr = 5;
    ex_redirect = 1;
    run(1);
    // 3-cycle wait
    clr(); mem_req = 1;
    run(3);
    dmem_ready = 1;
    run(1);
    clr(); run(1);
    // redirect held through a 2-cycle wait
    ex_redirect = 1; mem_req = 1;
    run(2);
    dmem_ready = 1;
    run(1);
    clr(); run(1);
    // protocol violation: mem_req drops mid-wait
    mem_req = 1; run(2);
    mem_req = 0; run(2);
    // timeout, then stuck until reset
    mem_req = 1; run(6);
    dmem_ready = 1; ex_redirect = 1; run(2);
    rst_n = 0; run(1);
    rst_n = 1; clr(); run(2);
    // reset mid-wait
    mem_req = 1; run(2);
    rst_n = 0; run(1);
    rst_n = 1; clr(); run(1);
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 59) != 0);
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      ex_rd_addr  = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 3) == 0);
      mem_req     = ($urandom_range(0, 9) < 7);
      dmem_ready  = ($urandom_range(0, 9) < 3);
      cycle();
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
